// File: rtl/pulse_event_counter.sv
// Counts synchronised event pulses over fixed windows and offers each count on a valid/ready register.
// Define PULSE_GAP_CHECK_EN to build the event-spacing check that drives gap_err.
module pulse_event_counter #(
    parameter int CNT_W   = 8,
    parameter int WINDOW  = 100,
    parameter int MIN_GAP = 4
) (
    input  logic             clk2,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun,
    output logic             gap_err
);

    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    state_t           state_next;
    logic             pulse_prev;
    logic             event_det;
    logic             win_end;
    logic             load_result;
    logic             drop_result;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] result;

    assign event_det = pulse_in & ~pulse_prev;
    assign win_end   = (win_cnt == WIN_LAST);
    assign acc_inc   = (acc == CNT_MAX) ? acc : acc + CNT_W'(1);
    // An event on the closing cycle still belongs to the window that is ending.
    assign result    = event_det ? acc_inc : acc;

    always_ff @(posedge clk2) begin
        if (reset) begin
            pulse_prev <= 1'b0;
            win_cnt    <= '0;
            acc        <= '0;
        end else begin
            pulse_prev <= pulse_in;
            win_cnt    <= win_end ? '0 : win_cnt + WIN_W'(1);
            if (win_end) begin
                acc <= '0;
            end else if (event_det) begin
                acc <= acc_inc;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (win_end) state_next = FULL;
            FULL:  if (cnt_ready && !win_end) state_next = EMPTY;
        endcase
    end

    // A full register only takes a new result when the old one is leaving on the same edge.
    always_comb begin
        load_result = 1'b0;
        drop_result = 1'b0;
        if (win_end) begin
            if (state == EMPTY || cnt_ready) begin
                load_result = 1'b1;
            end else begin
                drop_result = 1'b1;
            end
        end
    end

    assign cnt_valid = (state == FULL);

    always_ff @(posedge clk2) begin
        if (reset) begin
            cnt_out <= '0;
            overrun <= 1'b0;
        end else begin
            if (load_result) begin
                cnt_out <= result;
            end
            if (drop_result) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PULSE_GAP_CHECK_EN
    localparam int               GAP_W   = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

    logic [GAP_W-1:0] gap_cnt;

    // Starting saturated means the first event after reset is always far enough away.
    always_ff @(posedge clk2) begin
        if (reset) begin
            gap_cnt <= GAP_MAX;
            gap_err <= 1'b0;
        end else if (event_det) begin
            if (gap_cnt < GAP_MAX) begin
                gap_err <= 1'b1;
            end
            gap_cnt <= GAP_W'(1);
        end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`else
    assign gap_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_event_counter.sv
// Self-checking bench for pulse_event_counter: directed scenarios plus randomized traffic vs a window-count model.
module tb_pulse_event_counter;

    localparam int CNT_W   = 4;
    localparam int WINDOW  = 100;
    localparam int MIN_GAP = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PULSE_GAP_CHECK_EN
    localparam int GAP_ON = 1;
`else
    localparam int GAP_ON = 0;
`endif

    logic             clk2      = 1'b0;
    logic             reset     = 1'b1;
    logic             pulse_in  = 1'b0;
    logic             cnt_ready = 1'b0;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             overrun;
    logic             gap_err;

    always #5 clk2 = ~clk2;

    pulse_event_counter #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk2     (clk2),
        .reset    (reset),
        .pulse_in (pulse_in),
        .cnt_out  (cnt_out),
        .cnt_valid(cnt_valid),
        .cnt_ready(cnt_ready),
        .overrun  (overrun),
        .gap_err  (gap_err)
    );

    // Reference model: counts rising edges per window as a plain integer and clips at the end.
    int mCyc      = 0;
    int mCount    = 0;
    int mLastEv   = -1;
    int mOut      = 0;
    int mRes      = 0;
    bit mPrev     = 1'b0;
    bit mEv       = 1'b0;
    bit mValid    = 1'b0;
    bit mOverrun  = 1'b0;
    bit mGapErr   = 1'b0;
    bit modelReady = 1'b0;

    always @(posedge clk2) begin
        if (reset) begin
            mCyc = 0; mCount = 0; mLastEv = -1; mOut = 0; mPrev = 1'b0;
            mValid = 1'b0; mOverrun = 1'b0; mGapErr = 1'b0; modelReady = 1'b1;
        end else begin
            mEv   = pulse_in && !mPrev;
            mPrev = pulse_in;
            if (mEv) begin
                if (GAP_ON != 0 && mLastEv >= 0 && (mCyc - mLastEv) < MIN_GAP) mGapErr = 1'b1;
                mLastEv = mCyc;
                mCount++;
            end
            if (mCyc % WINDOW == WINDOW - 1) begin
                mRes   = (mCount > CNT_MAX) ? CNT_MAX : mCount;
                mCount = 0;
                if (!mValid || cnt_ready) begin
                    mOut   = mRes;
                    mValid = 1'b1;
                end else begin
                    mOverrun = 1'b1;
                end
            end else if (mValid && cnt_ready) begin
                mValid = 1'b0;
            end
            mCyc++;
        end
    end

    // Hand-computed expectations, indexed [field][cycle]; fields: 0 cnt_out, 1 cnt_valid, 2 overrun, 3 gap_err.
    bit expOn  [0:3][0:255];
    int expVal [0:3][0:255];
    int checks = 0;
    int passes = 0;

    function automatic string fieldName(input int f);
        case (f)
            0:       return "cnt_out";
            1:       return "cnt_valid";
            2:       return "overrun";
            default: return "gap_err";
        endcase
    endfunction

    function automatic logic [31:0] fieldAct(input int f);
        case (f)
            0:       return 32'(cnt_out);
            1:       return {31'b0, cnt_valid};
            2:       return {31'b0, overrun};
            default: return {31'b0, gap_err};
        endcase
    endfunction

    function automatic int fieldModel(input int f);
        case (f)
            0:       return mOut;
            1:       return int'(mValid);
            2:       return int'(mOverrun);
            default: return int'(mGapErr);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, actual, expected, mCyc, $time);
        end else begin
            passes++;
        end
    endtask

    // The single compare process: DUT vs model every cycle, plus literal pins on DUT and model.
    always @(negedge clk2) begin
        if (modelReady) begin
            for (int f = 0; f < 4; f++) begin
                checkOutput(fieldName(f), fieldAct(f), fieldModel(f));
            end
            if (mCyc < 256) begin
                for (int f = 0; f < 4; f++) begin
                    if (expOn[f][mCyc]) begin
                        checkOutput({"lit_", fieldName(f)}, fieldAct(f), expVal[f][mCyc]);
                        checkOutput({"model_", fieldName(f)}, 32'(fieldModel(f)), expVal[f][mCyc]);
                    end
                end
            end
        end
    end

    bit pulsePat [0:255];
    bit readyPat [0:255];

    task automatic applyStimulus(input bit rst, input bit p, input bit r);
        @(negedge clk2);
        reset     = rst;
        pulse_in  = p;
        cnt_ready = r;
    endtask

    task automatic expectAt(input int c, input int f, input int v);
        expOn[f][c]  = 1'b1;
        expVal[f][c] = v;
    endtask

    // Enter reset and clear pins/patterns once the model's cycle index is back at 0.
    task automatic startPhase();
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk2);
        #1;
        for (int c = 0; c < 256; c++) begin
            pulsePat[c] = 1'b0;
            readyPat[c] = 1'b0;
            for (int f = 0; f < 4; f++) expOn[f][c] = 1'b0;
        end
    endtask

    task automatic runCycles(input int len);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < len; c++) begin
            applyStimulus(1'b0, pulsePat[c], readyPat[c]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk2);
    endtask

    int density;
    int rstLen;

    initial begin
        $display("[TB] directed: three pulses, ready high");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        pulsePat[10] = 1'b1; pulsePat[20] = 1'b1; pulsePat[30] = 1'b1;
        for (int f = 0; f < 4; f++) expectAt(0, f, 0);
        expectAt(99, 1, 0);
        expectAt(100, 1, 1); expectAt(100, 0, 3);
        expectAt(101, 1, 0);
        runCycles(105);

        $display("[TB] directed: level held five cycles");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        for (int c = 10; c < 15; c++) pulsePat[c] = 1'b1;
        expectAt(100, 0, 1); expectAt(100, 1, 1);
        runCycles(105);

        $display("[TB] directed: pulse on window-end cycle");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        pulsePat[99] = 1'b1;
        expectAt(100, 0, 1); expectAt(100, 1, 1);
        expectAt(200, 0, 0); expectAt(200, 1, 1);
        runCycles(205);

        $display("[TB] directed: overrun with ready low");
        startPhase();
        for (int c = 205; c < 256; c++) readyPat[c] = 1'b1;
        pulsePat[10] = 1'b1; pulsePat[110] = 1'b1; pulsePat[120] = 1'b1;
        expectAt(100, 0, 1); expectAt(100, 2, 0);
        expectAt(199, 2, 0);
        expectAt(200, 0, 1); expectAt(200, 1, 1); expectAt(200, 2, 1);
        expectAt(206, 1, 0); expectAt(206, 2, 1); expectAt(206, 0, 1);
        runCycles(210);

        $display("[TB] directed: saturation with twenty events");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        for (int k = 0; k < 20; k++) pulsePat[10 + 2 * k] = 1'b1;
        expectAt(100, 0, CNT_MAX); expectAt(100, 3, GAP_ON);
        runCycles(105);

        $display("[TB] directed: close spacing");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        pulsePat[10] = 1'b1; pulsePat[12] = 1'b1;
        expectAt(12, 3, 0); expectAt(13, 3, GAP_ON);
        expectAt(100, 0, 2); expectAt(100, 3, GAP_ON);
        runCycles(105);

        $display("[TB] directed: legal spacing");
        startPhase();
        for (int c = 0; c < 256; c++) readyPat[c] = 1'b1;
        pulsePat[10] = 1'b1; pulsePat[14] = 1'b1; pulsePat[18] = 1'b1; pulsePat[22] = 1'b1;
        expectAt(30, 3, 0);
        expectAt(100, 0, 4); expectAt(100, 3, 0);
        runCycles(105);

        $display("[TB] randomized traffic");
        startPhase();
        applyStimulus(1'b1, 1'b0, 1'b0);
        density = 30;
        for (int c = 0; c < 3200; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0:       density = 5;
                    1:       density = 30;
                    2:       density = 60;
                    default: density = 92;
                endcase
            end
            if ($urandom_range(0, 1499) == 0) begin
                rstLen = $urandom_range(1, 3);
                for (int r = 0; r < rstLen; r++) applyStimulus(1'b1, 1'b0, 1'b0);
            end
            applyStimulus(1'b0, $urandom_range(0, 99) < density,
                          (c % 1000 < 400) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk2);
        @(negedge clk2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
